// File: rtl/mb_pkg.sv
// Shared MainBus definitions: bus widths, well-known register values and
// the initiator FSM state encoding.
package mb_pkg;

    localparam int MB_ADDR_W = 32;
    localparam int MB_DATA_W = 32;

    localparam logic [MB_DATA_W-1:0] MB_ID_CODE               = 32'h3500_0121;
    localparam logic [MB_DATA_W-1:0] MB_UNMAPPED_RDATA        = 32'hBEEF_BEEF;
    localparam logic [MB_DATA_W-1:0] MB_TIMEOUT_RDATA_DEFAULT = 32'hDEAD_DEAD;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } mb_state_e;

endpackage

// File: rtl/mb_timeout_counter.sv
// Saturating 8-bit WAIT-cycle counter; flags the last WAIT cycle an access
// may spend before it is aborted.
module mb_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic MB_clock,
    input  logic MB_reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // count holds WAIT cycles already elapsed, so the final permitted
    // cycle is the one where count == TIMEOUT_CYCLES-1.
    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge MB_clock or posedge MB_reset) begin
        if (MB_reset) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (enable) begin
            count <= sat_inc(count);
        end
    end

    assign expired = (count >= LIMIT);

endmodule

// File: rtl/mb_initiator.sv
// MainBus initiator: issues single-word register reads/writes to a MainBus
// slave and returns read data or a timeout indication to the requester.
module mb_initiator
    import mb_pkg::*;
#(
    parameter int unsigned          TIMEOUT_CYCLES = 16,
    parameter logic [MB_DATA_W-1:0] TIMEOUT_RDATA  = MB_TIMEOUT_RDATA_DEFAULT
) (
    input  logic                 MB_clock,
    input  logic                 MB_reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [MB_ADDR_W-1:0] cmd_addr,
    input  logic [MB_DATA_W-1:0] cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [MB_DATA_W-1:0] rsp_rdata,
    output logic                 rsp_timeout,
    output logic                 stray_done,
    output logic                 MB_sel_reg,
    output logic                 MB_write_strobe,
    output logic                 MB_read_strobe,
    output logic [MB_ADDR_W-1:0] MB_address,
    output logic [MB_DATA_W-1:0] MB_data_in,
    input  logic [MB_DATA_W-1:0] MB_data_out,
    input  logic                 MB_done
);

    mb_state_e state, state_nxt;
    logic      write_q;
    logic      accept;
    logic      cnt_clear;
    logic      cnt_en;
    logic      expired;

    // cmd_ready is the registered image of IDLE, low for the first cycle out of reset.
    assign accept = (state == ST_IDLE) && cmd_valid && cmd_ready;

    mb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_counter (
        .MB_clock (MB_clock),
        .MB_reset (MB_reset),
        .clear    (cnt_clear),
        .enable   (cnt_en),
        .expired  (expired)
    );

    always_ff @(posedge MB_clock or posedge MB_reset) begin
        if (MB_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_STROBE;
            end
            ST_STROBE: begin
                state_nxt = ST_WAIT;
                cnt_clear = 1'b1;
            end
            ST_WAIT: begin
                if (MB_done || expired) begin
                    state_nxt = ST_RESP;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // All requester- and bus-facing outputs are registered from the next state.
    always_ff @(posedge MB_clock or posedge MB_reset) begin
        if (MB_reset) begin
            cmd_ready       <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= '0;
            rsp_timeout     <= 1'b0;
            stray_done      <= 1'b0;
            MB_sel_reg      <= 1'b0;
            MB_write_strobe <= 1'b0;
            MB_read_strobe  <= 1'b0;
            MB_address      <= '0;
            MB_data_in      <= '0;
            write_q         <= 1'b0;
        end else begin
            cmd_ready       <= (state_nxt == ST_IDLE);
            rsp_valid       <= (state_nxt == ST_RESP);
            MB_sel_reg      <= (state_nxt == ST_STROBE);
            MB_write_strobe <= accept && cmd_write;
            MB_read_strobe  <= accept && !cmd_write;

            if (accept) begin
                write_q    <= cmd_write;
                MB_address <= cmd_addr;
                MB_data_in <= cmd_wdata;
            end

            // A done on the final counted cycle takes priority over the timeout.
            if (state == ST_WAIT) begin
                if (MB_done) begin
                    rsp_rdata   <= write_q ? '0 : MB_data_out;
                    rsp_timeout <= 1'b0;
                end else if (expired) begin
                    rsp_rdata   <= TIMEOUT_RDATA;
                    rsp_timeout <= 1'b1;
                end
            end

            if (MB_done && (state != ST_WAIT)) begin
                stray_done <= 1'b1;
            end
        end
    end

endmodule
